// File: rtl/apb_pkg.sv
// Shared APB/UART definitions: master FSM states and UART register map.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned UART_ADDR_W = 4;

    localparam logic [UART_ADDR_W-1:0] ADDR_TX          = 4'h0;
    localparam logic [UART_ADDR_W-1:0] ADDR_RX          = 4'h1;
    localparam logic [UART_ADDR_W-1:0] ADDR_BAUD        = 4'h2;
    localparam logic [UART_ADDR_W-1:0] ADDR_CONF        = 4'h3;
    localparam logic [UART_ADDR_W-1:0] ADDR_RXTRIG      = 4'h4;
    localparam logic [UART_ADDR_W-1:0] ADDR_TXTRIG      = 4'h5;
    localparam logic [UART_ADDR_W-1:0] ADDR_DELAY       = 4'h6;
    localparam logic [UART_ADDR_W-1:0] ADDR_STATUS      = 4'h7;
    localparam logic [UART_ADDR_W-1:0] ADDR_RXFIFO_STAT = 4'h8;
    localparam logic [UART_ADDR_W-1:0] ADDR_TXFIFO_STAT = 4'h9;

endpackage

// File: rtl/apb_master_own.sv
// APB initiator: one SETUP+ACCESS transfer per accepted command, response on a valid/ready port.
module apb_master_own
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    output logic              busy_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e         state;
    apb_state_e         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               timeout_hit_c;

    logic               cmd_ready_nxt;
    logic               rsp_valid_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt;
    logic               rsp_err_nxt;
    logic               psel_nxt;
    logic               penable_nxt;
    logic               pwrite_nxt;
    logic [ADDR_W-1:0]  paddr_nxt;
    logic [DATA_W-1:0]  pwdata_nxt;
    logic               busy_nxt;

    // Last permitted ACCESS cycle reached without pready (disabled when TIMEOUT is 0)
    assign timeout_hit_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cmd_valid_i) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (pready_i || timeout_hit_c) state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready_i) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and the wait counter
    always_comb begin
        cmd_ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt      = (state_nxt != ST_IDLE);
        rsp_valid_nxt = rsp_valid_o;
        rsp_rdata_nxt = rsp_rdata_o;
        rsp_err_nxt   = rsp_err_o;
        psel_nxt      = psel_o;
        penable_nxt   = penable_o;
        pwrite_nxt    = pwrite_o;
        paddr_nxt     = paddr_o;
        pwdata_nxt    = pwdata_o;
        cnt_nxt       = cnt;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    paddr_nxt   = cmd_addr_i;
                    pwdata_nxt  = cmd_wdata_i;
                    pwrite_nxt  = cmd_write_i;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                end
            end
            ST_SETUP: begin
                penable_nxt = 1'b1;
                cnt_nxt     = '0;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    rsp_rdata_nxt = pwrite_o ? '0 : prdata_i;
                    rsp_err_nxt   = 1'b0;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                end else if (timeout_hit_c) begin
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) rsp_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            cnt         <= '0;
        end else begin
            cmd_ready_o <= cmd_ready_nxt;
            busy_o      <= busy_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_rdata_o <= rsp_rdata_nxt;
            rsp_err_o   <= rsp_err_nxt;
            psel_o      <= psel_nxt;
            penable_o   <= penable_nxt;
            pwrite_o    <= pwrite_nxt;
            paddr_o     <= paddr_nxt;
            pwdata_o    <= pwdata_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_own.sv
// Self-checking bench for apb_master_own with a behavioural UART register slave.
module tb_apb_master_own;
    import apb_pkg::*;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // slave register file and the bench's expectation of it
    logic [DATA_W-1:0] mem      [16];
    logic [DATA_W-1:0] ref_regs [16];
    int hold_cfg = 0;
    int acc_seen = 0;

    apb_master_own #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Slave: real data and scripted wait states only in ACCESS, junk elsewhere
    always @(negedge clk) begin
        if (psel && penable) begin
            pready   = (acc_seen >= hold_cfg);
            prdata   = mem[paddr];
            acc_seen = acc_seen + 1;
        end else begin
            acc_seen = 0;
            pready   = 1'($urandom);
            prdata   = $urandom;
        end
    end

    // Slave write port; STATUS is write-1-to-clear
    always @(posedge clk) begin
        if (psel && penable && pready && pwrite) begin
            if (paddr == ADDR_STATUS) mem[paddr] = mem[paddr] & ~pwdata;
            else                      mem[paddr] = pwdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One command end to end; caller is positioned 1 time unit after a rising edge in IDLE
    task automatic txn(input bit w, input logic [3:0] a, input logic [31:0] d,
                       input int hold, input int rdly, input bit keep_valid);
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_acc;
        int          acc;
        bit          unstable;
        bit          rsp_moved;
        bit          rdy_seen;
        exp_err   = (hold >= int'(TIMEOUT));
        exp_acc   = exp_err ? int'(TIMEOUT) : hold + 1;
        exp_rdata = (w || exp_err) ? 32'h0 : ref_regs[a];
        hold_cfg  = hold;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1;
        if (!keep_valid) cmd_valid = 1'b0;
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_paddr", 32'(paddr), 32'(a));
        chk("setup_pwrite", 32'(pwrite), 32'(w));
        chk("setup_pwdata", pwdata, d);
        chk("setup_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
        @(posedge clk); #1;
        chk("access_psel_penable", {30'd0, psel, penable}, 32'd3);
        acc = 0; unstable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (penable) acc++;
            if (paddr !== a || pwrite !== w || pwdata !== d) unstable = 1'b1;
            @(posedge clk); #1;
            if (rsp_valid) break;
        end
        chk("access_cycles", 32'(acc), 32'(exp_acc));
        chk("apb_fields_stable", 32'(unstable), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("resp_apb_idle", {30'd0, psel, penable}, 32'd0);
        rsp_moved = 1'b0; rdy_seen = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) rsp_moved = 1'b1;
            if (cmd_ready !== 1'b0) rdy_seen = 1'b1;
        end
        chk("rsp_held", 32'(rsp_moved), 32'd0);
        chk("stall_cmd_ready", 32'(rdy_seen | cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_rsp_idle", {29'd0, cmd_ready, busy, psel}, 32'd4);
        if (w && !exp_err) begin
            if (a == ADDR_STATUS) ref_regs[a] = ref_regs[a] & ~d;
            else                  ref_regs[a] = d;
        end
    endtask

    initial begin
        bit          w;
        logic [3:0]  a;
        int          hold;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
        end
        mem[ADDR_BAUD]   = 32'h0000F152;
        mem[ADDR_RXTRIG] = 32'h00000001;
        mem[ADDR_STATUS] = 32'h00000003;
        for (int i = 0; i < 16; i++) ref_regs[i] = mem[i];

        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", {26'd0, cmd_ready, rsp_valid, rsp_err, psel, penable, busy}, 32'h20);
        chk("reset_apb_fields", {27'd0, pwrite, paddr}, 32'd0);
        chk("reset_data", pwdata | rsp_rdata, 32'd0);

        // directed register accesses
        txn(1'b0, ADDR_BAUD,   32'h0,  0,    0, 1'b0);
        txn(1'b1, ADDR_CONF,   32'h35, 0,    0, 1'b0);
        txn(1'b0, ADDR_CONF,   32'h0,  0,    0, 1'b0);
        txn(1'b1, ADDR_STATUS, 32'hF,  0,    0, 1'b0);
        txn(1'b0, ADDR_STATUS, 32'h0,  0,    0, 1'b0);
        txn(1'b0, ADDR_RXTRIG, 32'h0,  3,    0, 1'b0);
        txn(1'b0, ADDR_TX,     32'h0,  1000, 0, 1'b0);

        // back-pressured response with the next command already waiting
        txn(1'b0, ADDR_BAUD, 32'h0, 0, 5, 1'b1);
        @(posedge clk); #1;
        chk("pending_accepted_setup", {30'd0, psel, penable}, 32'd2);
        #2 rstn = 1'b0;
        #1;
        cmd_valid = 1'b0;
        chk("midreset_outputs", {26'd0, cmd_ready, rsp_valid, rsp_err, psel, penable, busy}, 32'h20);
        chk("midreset_apb_fields", {27'd0, pwrite, paddr}, 32'd0);
        chk("midreset_data", pwdata | rsp_rdata, 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            w    = 1'($urandom);
            a    = 4'($urandom_range(0, 9));
            hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 18)) : int'($urandom_range(0, 3));
            txn(w, a, $urandom, hold, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master_own.md
Name: apb_master_own

Overview:
APB initiator that drives the UART register interface (and any other APB slave in the subsystem) from a simple valid/ready command port.
- Converts each accepted command into one APB SETUP + ACCESS transfer.
- Returns read data or an error on a valid/ready response port.
- Sits between the CPU-side sequencer/test harness and the UART register block.

Parameters:
ADDR_W, 4, APB address width (UART register map occupies 0x0-0x9).
DATA_W, 32, APB data width.
TIMEOUT, 16, max ACCESS cycles waiting for pready_i before abort; 0 disables the timeout.

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  command accepted when high together with cmd_valid_i
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_W  target register address
cmd_wdata_i  input  DATA_W  write data (ignored for reads)
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  response consumed
rsp_rdata_o  output  DATA_W  read data (0 for writes and errors)
rsp_err_o  output  1  transfer aborted by timeout
psel_o  output  1  APB select
penable_o  output  1  APB enable
pwrite_o  output  1  APB direction
paddr_o  output  ADDR_W  APB address
pwdata_o  output  DATA_W  APB write data
prdata_i  input  DATA_W  APB read data
pready_i  input  1  APB ready; tie 1'b1 for slaves without wait states (UART register block)
busy_o  output  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o = 1. State = IDLE, timeout counter = 0.
- Reset mid-transfer drops the transfer immediately; no response is generated.
- All APB outputs are registered.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, capture addr/wdata/write into paddr_o/pwdata_o/pwrite_o.
  - Set psel_o = 1, penable_o = 0; go to SETUP.
- SETUP (exactly 1 cycle): set penable_o = 1; clear the counter; go to ACCESS.
- ACCESS:
  - If pready_i = 1: capture rsp_rdata_o = prdata_i for reads (0 for writes), rsp_err_o = 0. Clear psel_o and penable_o, set rsp_valid_o = 1, go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: rsp_rdata_o = 0, rsp_err_o = 1. Clear psel_o and penable_o, set rsp_valid_o = 1, go to RESP.
  - Else increment the counter; the counter saturates, no wrap.
- RESP: hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable until rsp_ready_i = 1. On that edge clear rsp_valid_o and go to IDLE.
- cmd_ready_o is 1 only in IDLE. Commands presented in other states stall without loss.
- Latency with pready_i = 1 (handshake at edge 0):
  - psel_o high in cycle 1.
  - penable_o high in cycle 2.
  - rsp_valid_o high in cycle 3.
  - Minimum issue interval is 4 cycles with rsp_ready_i tied 1.
- paddr_o, pwdata_o and pwrite_o are stable from SETUP through ACCESS and retain their last value in IDLE/RESP (no toggling).
- The UART slave registers prdata during SETUP. Sampling prdata_i at the ACCESS edge is therefore mandatory; earlier sampling is illegal.
- pready_i is ignored outside ACCESS. prdata_i is ignored for writes.
- A simultaneous response handshake and a new cmd_valid_i do not bypass IDLE; the new command is accepted in the following cycle.

Decomposition:
- Shared package apb_pkg contains:
  - the FSM state enum (IDLE/SETUP/ACCESS/RESP);
  - UART register address constants: TX=0x0, RX=0x1, BAUD=0x2, CONF=0x3, RXTRIG=0x4, TXTRIG=0x5, DELAY=0x6, STATUS=0x7, RXFIFO_STAT=0x8, TXFIFO_STAT=0x9.
- No sub-module; the timeout counter is inline.

Test Plan:
- Reset then read BAUD (0x2), pready_i = 1 -> psel_o cycle 1, penable_o cycle 2, rsp_valid_o cycle 3, rsp_rdata_o = 0x0000F152, rsp_err_o = 0.
- Write CONF = 0x00000035 then read CONF -> pwrite_o = 1 and pwdata_o = 0x35 stable across SETUP/ACCESS; read returns 0x00000035.
- Write STATUS = 0xF with the status register preloaded to 0x3 -> subsequent read returns 0x0 (write-1-to-clear through the master).
- pready_i held low 3 ACCESS cycles then high, read addr 0x4 -> penable_o high 4 cycles, rsp_rdata_o = 0x1, rsp_err_o = 0.
- pready_i stuck low, TIMEOUT = 16 -> abort after 16 ACCESS cycles; rsp_err_o = 1, rsp_rdata_o = 0, psel_o/penable_o low.
- rsp_ready_i low 5 cycles with cmd_valid_i high, then assert rstn low during a SETUP -> response held stable and cmd_ready_o = 0 while stalled; after reset all APB outputs are 0, cmd_ready_o = 1, no rsp_valid_o.
